fp_vector_addsub: RTL



---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_lane_addsub.sv | 169 ++++++++++++++++
 rtl/fp_vector_addsub.sv | 68 ++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the small-float vector add/sub datapath: default format widths,
// decoded-float struct, leading-zero count helper.
package fp_pkg;

    localparam int unsigned FP_EXP_BITS  = 5;
    localparam int unsigned FP_MANT_BITS = 6;
    localparam int unsigned FP_W         = 1 + FP_EXP_BITS + FP_MANT_BITS;
    localparam int unsigned FP_BIAS      = (1 << (FP_EXP_BITS - 1)) - 1;

    localparam logic [FP_EXP_BITS-1:0] ALL_ONES = '1;

    typedef struct packed {
        logic                    sign;
        logic [FP_EXP_BITS-1:0]  exp;
        logic [FP_MANT_BITS-1:0] mant;
    } fp_t;

    // Leading zeros of v[width-1:0]; returns width for an all-zero input.
    function automatic int unsigned lzc(input logic [63:0] v, input int unsigned width);
        int unsigned n;
        n = width;
        for (int i = 0; i < 64; i++) begin
            if (i < width && v[i]) begin
                n = width - 1 - i;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_lane_addsub.sv
// Single-lane 3-stage float add/sub: align, add, normalize/round. Each stage loads on its en_i bit.
// Rounding: nearest-even with FP_VECTOR_ADDSUB_RNE_EN defined, truncation otherwise.
module fp_lane_addsub
    import fp_pkg::*;
#(
    parameter int unsigned EXP_BITS  = FP_EXP_BITS,
    parameter int unsigned MANT_BITS = FP_MANT_BITS
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [2:0]                      en_i,
    input  logic                            sub_i,
    input  logic [EXP_BITS+MANT_BITS:0]     a_i,
    input  logic [EXP_BITS+MANT_BITS:0]     b_i,
    output logic [EXP_BITS+MANT_BITS:0]     sum_o,
    output logic                            of_o
);

    localparam int unsigned E     = EXP_BITS;
    localparam int unsigned M     = MANT_BITS;
    localparam int unsigned W     = 1 + E + M;
    localparam int unsigned XW    = M + 4;
    localparam int unsigned SW    = M + 5;
    localparam int unsigned EW    = E + 2;
    localparam int unsigned WW    = 2 * M + 6;
    localparam int unsigned MaxSh = M + 3;
    localparam logic [E-1:0] ExpMax = '1;

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [M-1:0] mant;
    } lane_fp_t;

    lane_fp_t a, b_eff, l, s;
    logic a_ge, zneg_d;
    logic [E-1:0] l_eexp, s_eexp, diff;
    int unsigned sh1;
    logic [WW-1:0] align;
    logic [XW-1:0] ml_d, ms_d;

    logic          s1_sign_q, s1_sub_q, s1_zneg_q;
    logic [E-1:0]  s1_exp_q;
    logic [XW-1:0] s1_ml_q, s1_ms_q;

    logic [SW-1:0] s2_sum_d, s2_sum_q;
    logic [E-1:0]  s2_exp_q;
    logic          s2_sign_q, s2_zneg_q;

    logic [XW-1:0] v;
    logic [EW-1:0] e;
    int unsigned   lz, lim, sh3;
    logic [M:0]    sig_f;
    logic [W-1:0]  res_d, sum_q;
    logic          of_d, of_q;
`ifdef FP_VECTOR_ADDSUB_RNE_EN
    logic          inc;
    logic [M+1:0]  sig_r;
`else
    logic          unused_grs;
`endif

    // Stage 1: order by magnitude, align the smaller significand with guard/round/sticky.
    always_comb begin
        a           = a_i;
        b_eff       = b_i;
        b_eff.sign  = b_i[W-1] ^ sub_i;
        a_ge        = {a.exp, a.mant} >= {b_eff.exp, b_eff.mant};
        l           = a_ge ? a : b_eff;
        s           = a_ge ? b_eff : a;
        l_eexp      = (l.exp == '0) ? E'(1) : l.exp;
        s_eexp      = (s.exp == '0) ? E'(1) : s.exp;
        diff        = l_eexp - s_eexp;
        sh1         = (32'(diff) > MaxSh) ? MaxSh : 32'(diff);
        align       = {(s.exp != '0), s.mant, {(M + 5){1'b0}}} >> sh1;
        ms_d        = {align[WW-1:M+3], |align[M+2:0]};
        ml_d        = {(l.exp != '0), l.mant, 3'b000};
        zneg_d      = (a.exp == '0) && (a.mant == '0) && (b_eff.exp == '0) &&
                      (b_eff.mant == '0) && a.sign && b_eff.sign;
    end

    always_comb begin
        s2_sum_d = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                            : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
    end

    // Stage 3: normalize (left shift floored at the subnormal exponent), round, saturate.
    always_comb begin
        v     = '0;
        e     = '0;
        lz    = 0;
        lim   = 0;
        sh3   = 0;
        sig_f = '0;
        res_d = '0;
        of_d  = 1'b0;
        if (s2_sum_q[SW-1]) begin
            v = {s2_sum_q[SW-1:2], |s2_sum_q[1:0]};
            e = EW'(s2_exp_q) + EW'(1);
        end else begin
            lz  = lzc(64'(s2_sum_q[XW-1:0]), XW);
            lim = 32'(s2_exp_q) - 1;
            sh3 = (lz < lim) ? lz : lim;
            v   = s2_sum_q[XW-1:0] << sh3;
            e   = EW'(s2_exp_q) - EW'(sh3);
        end
`ifdef FP_VECTOR_ADDSUB_RNE_EN
        inc   = v[2] & (v[1] | v[0] | v[3]);
        sig_r = {1'b0, v[XW-1:3]} + (M + 2)'(inc);
        if (sig_r[M+1]) begin
            sig_f = sig_r[M+1:1];
            e     = e + EW'(1);
        end else begin
            sig_f = sig_r[M:0];
        end
`else
        unused_grs = ^v[2:0];
        sig_f      = v[XW-1:3];
`endif
        if (s2_sum_q == '0) begin
            res_d = {s2_zneg_q, {(W - 1){1'b0}}};
        end else if (e > EW'(ExpMax)) begin
            res_d = {s2_sign_q, ExpMax, {M{1'b1}}};
            of_d  = 1'b1;
        end else begin
            res_d = {s2_sign_q, (sig_f[M] ? e[E-1:0] : {E{1'b0}}), sig_f[M-1:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_sign_q <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_zneg_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_ml_q   <= '0;
            s1_ms_q   <= '0;
            s2_sum_q  <= '0;
            s2_exp_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_zneg_q <= 1'b0;
            sum_q     <= '0;
            of_q      <= 1'b0;
        end else begin
            if (en_i[0]) begin
                s1_sign_q <= l.sign;
                s1_sub_q  <= a.sign ^ b_eff.sign;
                s1_zneg_q <= zneg_d;
                s1_exp_q  <= l_eexp;
                s1_ml_q   <= ml_d;
                s1_ms_q   <= ms_d;
            end
            if (en_i[1]) begin
                s2_sum_q  <= s2_sum_d;
                s2_exp_q  <= s1_exp_q;
                s2_sign_q <= s1_sign_q;
                s2_zneg_q <= s1_zneg_q;
            end
            if (en_i[2]) begin
                sum_q <= res_d;
                of_q  <= of_d;
            end
        end
    end

    assign sum_o = sum_q;
    assign of_o  = of_q;

endmodule

// File: rtl/fp_vector_addsub.sv
// LANES-wide float add/sub, 3-stage pipeline with valid/ready and bubble-collapsing stall.
// Build option FP_VECTOR_ADDSUB_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_vector_addsub
    import fp_pkg::*;
#(
    parameter int unsigned EXP_BITS  = FP_EXP_BITS,
    parameter int unsigned MANT_BITS = FP_MANT_BITS,
    parameter int unsigned LANES     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [LANES-1:0]                        in_sub,
    input  logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] in_a,
    input  logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] in_b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] out_sum,
    output logic [LANES-1:0]                        out_of
);

    localparam int unsigned W = 1 + EXP_BITS + MANT_BITS;

    logic v1_q, v2_q, v3_q;
    logic stall;
    logic [2:0] en;

    // A stage loads whenever it is empty or the stage after it is moving.
    always_comb begin
        stall    = v3_q & ~out_ready;
        in_ready = ~stall;
        en[2]    = ~v3_q | out_ready;
        en[1]    = ~v2_q | en[2];
        en[0]    = ~v1_q | en[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en[0]) v1_q <= in_valid & in_ready;
            if (en[1]) v2_q <= v1_q;
            if (en[2]) v3_q <= v2_q;
        end
    end

    assign out_valid = v3_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_lane_addsub #(
            .EXP_BITS  (EXP_BITS),
            .MANT_BITS (MANT_BITS)
        ) u_lane (
            .clk_i (clk),
            .rst_i (rst),
            .en_i  (en),
            .sub_i (in_sub[i]),
            .a_i   (in_a[i*W +: W]),
            .b_i   (in_b[i*W +: W]),
            .sum_o (out_sum[i*W +: W]),
            .of_o  (out_of[i])
        );
    end

endmodule
